// File: rtl/sid_pkg.sv
// -----------------------------------------------------------------------------
// sid_pkg
// Definitions shared by the SID register writer: bus widths, the writer
// FSM state type, well-known SID register addresses, and a helper that packs a
// command into a FIFO word.
// Ports: none (package).
// -----------------------------------------------------------------------------
package sid_pkg;

   localparam int SID_ADDR_W = 5;
   localparam int SID_DATA_W = 8;
   localparam int SID_CMD_W  = SID_ADDR_W + SID_DATA_W;

   // Filter register addresses in the SID register bank
   localparam logic [SID_ADDR_W-1:0] FC_LO    = 5'h15;
   localparam logic [SID_ADDR_W-1:0] FC_HI    = 5'h16;
   localparam logic [SID_ADDR_W-1:0] RES_FILT = 5'h17;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } sid_state_t;

   // A FIFO word holds the address in the upper bits and the data in the lower bits
   function automatic logic [SID_CMD_W-1:0] pack_cmd(
      input logic [SID_ADDR_W-1:0] addr,
      input logic [SID_DATA_W-1:0] data
   );
      return {addr, data};
   endfunction

endpackage

// File: rtl/sid_cmd_fifo.sv
// -----------------------------------------------------------------------------
// sid_cmd_fifo
// Synchronous command FIFO for the SID register writer. The head entry is
// presented combinationally so the writer can latch it on the same edge it
// pops. Pointers wrap modulo DEPTH (DEPTH must be a power of two).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and data (ignored when full)
//   pop                 read request (ignored when empty)
//   pop_data            current head entry
//   level               occupancy, 0..DEPTH
//   full, empty         occupancy flags
// -----------------------------------------------------------------------------
module sid_cmd_fifo
   import sid_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = SID_CMD_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;
   logic             do_push;
   logic             do_pop;

   assign full     = (level_reg == FULL_LVL);
   assign empty    = (level_reg == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign level    = level_reg;
   assign pop_data = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         // Push and pop together leave the occupancy unchanged
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once the level says valid
   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/sid_reg_writer.sv
// -----------------------------------------------------------------------------
// sid_reg_writer
// Queues host register-write commands and replays them to the SID register
// bank as single-cycle WR strobes, with at least GAP idle cycles between
// strobes. Optional shadow copy of the register bank is enabled by defining
// the macro SID_REG_WRITER_SHADOW_EN.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   iValid/oReady          command handshake
//   iAddr, iData           command address and data
//   WR, ADDR, DATA         register bank write strobe, address, data
//   oLevel                 FIFO occupancy
//   oBusy                  FIFO non-empty or write sequence in progress
//   iRdAddr, oRdData       shadow read port (SID_REG_WRITER_SHADOW_EN only)
// -----------------------------------------------------------------------------
module sid_reg_writer
   import sid_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GAP   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     iValid,
   output logic                     oReady,
   input  logic [SID_ADDR_W-1:0]    iAddr,
   input  logic [SID_DATA_W-1:0]    iData,
   output logic                     WR,
   output logic [SID_ADDR_W-1:0]    ADDR,
   output logic [SID_DATA_W-1:0]    DATA,
   output logic [$clog2(DEPTH):0]   oLevel,
   output logic                     oBusy
`ifdef SID_REG_WRITER_SHADOW_EN
   ,
   input  logic [SID_ADDR_W-1:0]    iRdAddr,
   output logic [SID_DATA_W-1:0]    oRdData
`endif
);

   // Counter is loaded with GAP-1 so the FSM spends exactly GAP cycles in ST_GAP
   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   sid_state_t             state_reg;
   logic [3:0]             gap_cnt_reg;
   logic                   wr_reg;
   logic [SID_ADDR_W-1:0]  addr_reg;
   logic [SID_DATA_W-1:0]  data_reg;

   logic [SID_CMD_W-1:0]   head_cmd;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;

   // Head is consumed on the same edge that launches the strobe
   assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;

   sid_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SID_CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (iValid),
      .push_data (pack_cmd(iAddr, iData)),
      .pop       (fifo_pop),
      .pop_data  (head_cmd),
      .level     (oLevel),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign oReady = !fifo_full;
   assign oBusy  = !fifo_empty || (state_reg != ST_IDLE);
   assign WR     = wr_reg;
   assign ADDR   = addr_reg;
   assign DATA   = data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         gap_cnt_reg <= '0;
         wr_reg      <= 1'b0;
         addr_reg    <= '0;
         data_reg    <= '0;
      end else begin
         wr_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  wr_reg    <= 1'b1;
                  addr_reg  <= head_cmd[SID_CMD_W-1 -: SID_ADDR_W];
                  data_reg  <= head_cmd[SID_DATA_W-1:0];
                  state_reg <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (GAP > 0) begin
                  state_reg   <= ST_GAP;
                  gap_cnt_reg <= GAP_LOAD;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gap_cnt_reg == 4'd0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 4'd1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef SID_REG_WRITER_SHADOW_EN
   localparam int SHADOW_N = 1 << SID_ADDR_W;

   logic [SID_DATA_W-1:0] shadow_reg [SHADOW_N];
   logic [SHADOW_N-1:0]   shadow_we;

   // One-hot write enable decoded from the issued strobe
   generate
      for (genvar gi = 0; gi < SHADOW_N; gi++) begin : g_shadow_we
         assign shadow_we[gi] = wr_reg && (addr_reg == SID_ADDR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SHADOW_N; i++) shadow_reg[i] <= '0;
      end else begin
         for (int i = 0; i < SHADOW_N; i++) begin
            if (shadow_we[i]) shadow_reg[i] <= data_reg;
         end
      end
   end

   assign oRdData = shadow_reg[iRdAddr];
`endif

endmodule

// File: tb/tb_sid_reg_writer.sv
// -----------------------------------------------------------------------------
// tb_sid_reg_writer
// Self-checking bench for sid_reg_writer. A queue of accepted-but-not-issued
// commands is the reference: it predicts occupancy, ready, busy, when the
// next strobe is due, and what address/data it must carry.
// -----------------------------------------------------------------------------
module tb_sid_reg_writer;

   localparam int TB_DEPTH = 4;
   localparam int TB_GAP   = 2;

   logic       clk;
   logic       rst_n;
   logic       iValid;
   logic       oReady;
   logic [4:0] iAddr;
   logic [7:0] iData;
   logic       WR;
   logic [4:0] ADDR;
   logic [7:0] DATA;
   logic [2:0] oLevel;
   logic       oBusy;
`ifdef SID_REG_WRITER_SHADOW_EN
   logic [4:0] iRdAddr;
   logic [7:0] oRdData;
`endif

   sid_reg_writer #(
      .DEPTH (TB_DEPTH),
      .GAP   (TB_GAP)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .iValid  (iValid),
      .oReady  (oReady),
      .iAddr   (iAddr),
      .iData   (iData),
      .WR      (WR),
      .ADDR    (ADDR),
      .DATA    (DATA),
      .oLevel  (oLevel),
      .oBusy   (oBusy)
`ifdef SID_REG_WRITER_SHADOW_EN
      ,
      .iRdAddr (iRdAddr),
      .oRdData (oRdData)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   // Reference state
   logic [12:0] mdl_q[$];       // accepted commands not yet strobed
   int          since = 100;    // cycles since the last strobe (0 on the strobe cycle)
   logic [4:0]  last_addr = '0;
   logic [7:0]  last_data = '0;
   logic        last_acc = 1'b0;
   int          wr_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are sampled at the edge, outputs checked 1 time unit later
   task automatic tick();
      logic        acc;
      logic        exp_wr;
      logic [12:0] cmd;
      acc    = iValid && oReady;
      // A strobe is due if something was queued and the writer had finished its gap
      exp_wr = (mdl_q.size() > 0) && (since >= TB_GAP + 1);
      @(posedge clk);
      #1;
      last_acc = acc;
      if (acc) mdl_q.push_back({iAddr, iData});
      chk("wr", WR, exp_wr);
      if (WR === 1'b1) begin
         wr_seen++;
         if (mdl_q.size() > 0) begin
            cmd = mdl_q.pop_front();
            last_addr = cmd[12:8];
            last_data = cmd[7:0];
         end
         since = 0;
      end else if (since < 100) begin
         since++;
      end
      chk("addr", ADDR, last_addr);
      chk("data", DATA, last_data);
      chk("level", oLevel, mdl_q.size());
      chk("ready", oReady, mdl_q.size() != TB_DEPTH);
      chk("busy", oBusy, (mdl_q.size() > 0) || (since <= TB_GAP));
   endtask

   // Present one command and hold it until accepted (bounded)
   task automatic send(input logic [4:0] a, input logic [7:0] d);
      int n;
      iValid = 1'b1;
      iAddr  = a;
      iData  = d;
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 40);
      if (!last_acc) chk("send_timeout", last_acc, 1);
   endtask

   task automatic idle(input int n);
      iValid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_wr"}, WR, 0);
      chk({tag, "_addr"}, ADDR, 0);
      chk({tag, "_data"}, DATA, 0);
      chk({tag, "_level"}, oLevel, 0);
      chk({tag, "_busy"}, oBusy, 0);
      iValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mdl_q.delete();
      since     = 100;
      last_addr = '0;
      last_data = '0;
      #1;
      chk({tag, "_ready"}, oReady, 1);
   endtask

   initial begin
      int wr_before;
      rst_n  = 1'b1;
      iValid = 1'b0;
      iAddr  = '0;
      iData  = '0;
`ifdef SID_REG_WRITER_SHADOW_EN
      iRdAddr = '0;
`endif
      #1;
      apply_reset("por");

      // Single write; latency and busy fall are checked cycle by cycle in tick
      send(5'h15, 8'h05);
      idle(1);
      chk("single_issued", wr_seen, 1);
      idle(6);

      // Burst of four back-to-back commands
      send(5'h15, 8'h11);
      send(5'h16, 8'h22);
      send(5'h17, 8'h33);
      send(5'h03, 8'h44);
      idle(20);
      chk("burst_issued", wr_seen, 5);

      // Six commands with iValid held: FIFO fills, stalls and drains in order
      for (int k = 0; k < 6; k++) send(5'(k + 8), 8'(8'hC0 + k));
      idle(24);
      chk("full_issued", wr_seen, 11);

      // Ten sequential commands wrap the pointers more than once
      for (int k = 0; k < 10; k++) send(5'($urandom), 8'($urandom));
      idle(24);
      chk("wrap_issued", wr_seen, 21);
      chk("wrap_drained", oLevel, 0);

      // Reset with three commands still queued
      for (int k = 0; k < 4; k++) send(5'(k + 1), 8'(8'h50 + k));
      iValid = 1'b0;
      chk("pre_reset_level", oLevel, 3);
      #1;
      apply_reset("mid");
      wr_before = wr_seen;
      idle(12);
      chk("no_wr_after_reset", wr_seen, wr_before);

      // Shadow write/read back right after a reset so every other entry is zero
      send(5'h17, 8'hA0);
      idle(6);
`ifdef SID_REG_WRITER_SHADOW_EN
      iRdAddr = 5'h17;
      #1;
      chk("shadow_17", oRdData, 8'hA0);
      iRdAddr = 5'h15;
      #1;
      chk("shadow_15", oRdData, 8'h00);
      iRdAddr = 5'h1F;
      #1;
      chk("shadow_1f", oRdData, 8'h00);
      iRdAddr = 5'h00;
      #1;
      chk("shadow_00", oRdData, 8'h00);
`endif

      // Randomised traffic with random valid gaps
      for (int c = 0; c < 300; c++) begin
         iValid = ($urandom_range(0, 3) != 0);
         iAddr  = 5'($urandom);
         iData  = 8'($urandom);
         tick();
      end
      idle(30);
      chk("random_drained", oLevel, 0);
      chk("random_idle", oBusy, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/sid_reg_writer.md
SID_REG_WRITER -- requirements
Module: sid_reg_writer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set command FIFO entries (power of two, 2..16).
REQ-002 Parameter GAP, default 2, SHALL set the minimum idle cycles between consecutive WR strobes (0..15).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 iValid  in  1  host command valid.
REQ-006 oReady  out  1  writer can accept a command.
REQ-007 iAddr  in  5  target SID register address.
REQ-008 iData  in  8  byte to write.
REQ-009 WR  out  1  single-cycle register write strobe to the SID register bank.
REQ-010 ADDR  out  5  write address, valid while WR=1.
REQ-011 DATA  out  8  write data, valid while WR=1.
REQ-012 oLevel  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 oBusy  out  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-014 A command SHALL be accepted on a rising edge where iValid=1 and oReady=1; iAddr/iData are captured into the FIFO tail.
REQ-015 oReady SHALL equal (oLevel != DEPTH), purely from registered state; no accept when full even if a pop occurs in the same cycle.
REQ-016 FSM states: IDLE, ISSUE, GAP.
REQ-017 IDLE -> ISSUE on the edge where FIFO is non-empty; that edge registers WR=1, ADDR/DATA=head entry, and pops the head.
REQ-018 ISSUE -> GAP if GAP>0 (counter loaded with GAP-1), else ISSUE -> IDLE; WR SHALL be high for exactly one cycle per command.
REQ-019 GAP decrements each cycle; GAP -> IDLE when counter reaches 0; no WR during GAP.
REQ-020 Latency: command accepted at edge N into an empty, idle writer SHALL produce WR=1 during the cycle after edge N+1.
REQ-021 Back-to-back throughput: one WR per GAP+2 cycles while FIFO non-empty (GAP=0: every 2 cycles).
REQ-022 Commands SHALL be issued in acceptance order, none dropped or duplicated.
REQ-023 Simultaneous push and pop SHALL leave oLevel unchanged; FIFO pointers wrap modulo DEPTH.
REQ-024 ADDR/DATA SHALL hold their last issued values while WR=0.

Reset
REQ-025 rst_n=0 SHALL immediately force WR=0, ADDR=0, DATA=0, oLevel=0, oBusy=0, FSM=IDLE, GAP counter=0; oReady=1 after deassertion.
REQ-026 Reset mid-operation SHALL discard all pending FIFO entries; no WR after release until a new command is accepted.

Configuration
REQ-027 Macro SID_REG_WRITER_SHADOW_EN, when defined, SHALL add port iRdAddr (in 5) and oRdData (out 8) plus a 32x8 shadow array updated on every WR with DATA at ADDR; oRdData combinationally returns shadow[iRdAddr]; shadow cleared to 0 on reset.
REQ-028 Without SID_REG_WRITER_SHADOW_EN, ports iRdAddr/oRdData and the shadow array SHALL not exist; all other behaviour is identical.

Structure
REQ-029 Shared package sid_pkg SHALL hold SID_ADDR_W=5, SID_DATA_W=8, the FSM state enum and the register address constants (FC_LO=0x15, FC_HI=0x16, RES_FILT=0x17).
REQ-030 FIFO SHALL be a sub-module sid_cmd_fifo (DEPTH, width 13, push/pop/level/full/empty); FSM and shadow stay in sid_reg_writer.

Verification
REQ-031 Single write: accept {0x15,0x05} at edge N -> WR=1, ADDR=0x15, DATA=0x05 for exactly one cycle after edge N+1; oBusy falls after GAP cycles.
REQ-032 Burst: 4 commands back-to-back, GAP=2 -> WR pulses spaced 4 cycles, order preserved; oReady=0 while oLevel=4.
REQ-033 Full boundary: hold iValid=1 with 6 commands, DEPTH=4 -> at most 4 queued, stalled commands accepted in order as entries drain, none lost.
REQ-034 Simultaneous push/pop at oLevel=2 -> oLevel stays 2; pointer wrap exercised with 10 sequential commands, all 10 issued in order.
REQ-035 Reset mid-burst with 3 pending -> WR=0 immediately, oLevel=0, no WR after release until new command.
REQ-036 SID_REG_WRITER_SHADOW_EN defined: write {0x17,0xA0} -> after WR, iRdAddr=0x17 returns 0xA0; other addresses read 0.
